serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_if.sv | 30 +++
 rtl/serial_addsub.sv | 144 ++++++++++++++
 tb/tb_serial_addsub.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Serial add/subtract interface: operand bit stream in, result bit stream and frame status out.
// Latency: none, this is wiring only.
// Backpressure: none; the stream is never stalled.
// Ports: start/mode/in1/in2 drive the datapath (master -> slave);
//        out/out_valid/busy/done/result/carry_out/overflow report back (slave -> master).
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic             in1;
  logic             in2;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, mode, in1, in2,
    input  out, out_valid, busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, mode, in1, in2,
    output out, out_valid, busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial LSB-first adder/subtractor over WIDTH-bit frames with parallel result capture.
// Latency: each result bit is registered one cycle after its operand bits; done follows the MSB by one cycle.
// Backpressure: none; one bit is consumed every cycle of a frame and frames may run back to back.
// Ports: clk, reset (synchronous, active-low); bus (slave modport) carries start/mode/in1/in2
//        in and out/out_valid/busy/done/result/carry_out/overflow out.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_addsub_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             carry, carry_nxt;
  logic             mode_q, mode_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;

  logic             out_r, out_nxt;
  logic             out_valid_r, out_valid_nxt;
  logic             done_r, done_nxt;
  logic [WIDTH-1:0] result_r, result_nxt;
  logic             carry_out_r, carry_out_nxt;
  logic             overflow_r, overflow_nxt;

  // per-bit datapath
  logic             consume;
  logic             m_eff;
  logic             c_in;
  logic [CW-1:0]    idx;
  logic             b;
  logic             s;
  logic             c_out;
  logic             last;

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    carry_nxt     = carry;
    mode_nxt      = mode_q;
    acc_nxt       = acc;
    out_nxt       = out_r;
    out_valid_nxt = 1'b0;
    done_nxt      = 1'b0;
    result_nxt    = result_r;
    carry_out_nxt = carry_out_r;
    overflow_nxt  = overflow_r;

    consume = 1'b0;
    m_eff   = mode_q;
    c_in    = carry;
    idx     = count;

    case (state)
      IDLE: begin
        // Frame start: mode is taken straight from the pins, and the carry is
        // seeded with mode so subtract becomes in1 + ~in2 + 1.
        if (bus.start) begin
          consume = 1'b1;
          m_eff   = bus.mode;
          c_in    = bus.mode;
          idx     = '0;
        end
      end
      RUN: begin
        consume = 1'b1;
      end
      default: begin
        consume = 1'b0;
      end
    endcase

    b     = bus.in2 ^ m_eff;
    s     = bus.in1 ^ b ^ c_in;
    c_out = (bus.in1 & b) | (bus.in1 & c_in) | (b & c_in);
    last  = (idx == CW'(WIDTH - 1));

    if (consume) begin
      out_nxt       = s;
      out_valid_nxt = 1'b1;
      carry_nxt     = c_out;
      mode_nxt      = m_eff;
      // Shift in from the top: after WIDTH bits the LSB has reached bit 0,
      // and any bits of an aborted frame have been pushed out.
      acc_nxt            = acc >> 1;
      acc_nxt[WIDTH-1]   = s;
      if (last) begin
        state_nxt     = IDLE;
        count_nxt     = '0;
        carry_nxt     = 1'b0;
        done_nxt      = 1'b1;
        result_nxt    = acc_nxt;
        carry_out_nxt = c_out;
        overflow_nxt  = c_in ^ c_out;
      end else begin
        state_nxt = RUN;
        count_nxt = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      carry       <= 1'b0;
      mode_q      <= 1'b0;
      acc         <= '0;
      out_r       <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      carry       <= carry_nxt;
      mode_q      <= mode_nxt;
      acc         <= acc_nxt;
      out_r       <= out_nxt;
      out_valid_r <= out_valid_nxt;
      done_r      <= done_nxt;
      result_r    <= result_nxt;
      carry_out_r <= carry_out_nxt;
      overflow_r  <= overflow_nxt;
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = (state == RUN);
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: table-driven frames plus hand sequences, scoreboard on the serial and parallel outputs.
// Latency: expects each result bit one cycle after its operands and done eight cycles after the start cycle.
// Backpressure: none; stimulus streams one bit per cycle.
module tb_serial_addsub;
  logic clk;
  logic reset;

  serial_addsub_if #(.WIDTH(8)) bus ();
  serial_addsub_if #(.WIDTH(1)) bus1 ();

  serial_addsub #(.WIDTH(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
  serial_addsub #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
  } res_t;

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       v;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_done = 0;
  int   prev_done = 0;
  int   done_cnt  = 0;
  int   frames_sent = 0;
  int   run = 0;
  int   max_run = 0;
  bit   mon_en = 0;
  logic bitq[$];
  res_t resq[$];
  res_t exp_hold;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic at word level: two's-complement sign rule for overflow.
  function automatic res_t model(input logic m, input logic [7:0] a, input logic [7:0] b);
    res_t       r;
    logic [7:0] bb;
    logic [8:0] f;
    bb  = m ? ~b : b;
    f   = {1'b0, a} + {1'b0, bb} + {8'd0, m};
    r.r = f[7:0];
    r.c = f[8];
    r.v = (a[7] == bb[7]) && (f[7] != a[7]);
    return r;
  endfunction

  // Scoreboard side: serial bits and completed frames from the WIDTH=8 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (bitq.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          chk("out_bit", {31'd0, bus.out}, {31'd0, bitq.pop_front()});
        end
      end else begin
        run = 0;
      end
      if (bus.done) begin
        res_t r;
        done_cnt++;
        prev_done = last_done;
        last_done = cyc;
        if (resq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = resq.pop_front();
          chk("result",    {24'd0, bus.result},  {24'd0, r.r});
          chk("carry_out", {31'd0, bus.carry_out}, {31'd0, r.c});
          chk("overflow",  {31'd0, bus.overflow},  {31'd0, r.v});
          exp_hold = r;
        end
      end else begin
        chk("result_hold", {22'd0, bus.result, bus.carry_out, bus.overflow},
            {22'd0, exp_hold.r, exp_hold.c, exp_hold.v});
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus.start = 1'b0;
      bus.mode  = 1'($urandom_range(0, 1));
      bus.in1   = 1'($urandom_range(0, 1));
      bus.in2   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic m, input logic [7:0] a, input logic [7:0] b,
                            input res_t e, input bit noisy);
    for (int i = 0; i < 8; i++) bitq.push_back(e.r[i]);
    resq.push_back(e);
    frames_sent++;
    for (int i = 0; i < 8; i++) begin
      bus.start = (i == 0) || (noisy && (i % 2 == 1));
      bus.mode  = (i == 0) ? m : (noisy ? 1'(i % 2) : m);
      bus.in1   = a[i];
      bus.in2   = b[i];
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  vec_t vt[6];

  initial begin
    int   s_cyc;
    res_t e;
    logic m;
    logic [7:0] a, b;

    vt[0] = '{m: 1'b0, a: 8'h3C, b: 8'h0F, r: 8'h4B, c: 1'b0, v: 1'b0};
    vt[1] = '{m: 1'b0, a: 8'h7F, b: 8'h01, r: 8'h80, c: 1'b0, v: 1'b1};
    vt[2] = '{m: 1'b0, a: 8'hFF, b: 8'h01, r: 8'h00, c: 1'b1, v: 1'b0};
    vt[3] = '{m: 1'b1, a: 8'h05, b: 8'h07, r: 8'hFE, c: 1'b0, v: 1'b0};
    vt[4] = '{m: 1'b1, a: 8'h80, b: 8'h01, r: 8'h7F, c: 1'b1, v: 1'b1};
    vt[5] = '{m: 1'b1, a: 8'h00, b: 8'h00, r: 8'h00, c: 1'b1, v: 1'b0};

    exp_hold  = '{r: 8'h00, c: 1'b0, v: 1'b0};
    reset     = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.in1 = 1'b0; bus.in2 = 1'b0;
    bus1.start = 1'b0; bus1.mode = 1'b0; bus1.in1 = 1'b0; bus1.in2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out",       {31'd0, bus.out},       32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_done",      {31'd0, bus.done},      32'd0);
    chk("rst_result",    {24'd0, bus.result},    32'd0);
    chk("rst_carry_out", {31'd0, bus.carry_out}, 32'd0);
    chk("rst_overflow",  {31'd0, bus.overflow},  32'd0);
    mon_en = 1;
    #1;
    reset = 1'b1;

    // Table frames, each separated by a short idle gap with random operand noise.
    foreach (vt[i]) begin
      e = '{r: vt[i].r, c: vt[i].c, v: vt[i].v};
      s_cyc = cyc;
      send_frame(vt[i].m, vt[i].a, vt[i].b, e, 0);
      idle(2);
      chk("done_latency", last_done - s_cyc, 32'd8);
    end

    // Back-to-back frames: continuous out_valid, done pulses eight cycles apart.
    max_run = 0;
    send_frame(1'b0, 8'h01, 8'h01, '{r: 8'h02, c: 1'b0, v: 1'b0}, 0);
    send_frame(1'b1, 8'h00, 8'h01, '{r: 8'hFF, c: 1'b0, v: 1'b0}, 0);
    idle(2);
    chk("b2b_valid_run", max_run, 32'd16);
    chk("b2b_done_gap", last_done - prev_done, 32'd8);

    // start/mode toggling during RUN must be ignored.
    send_frame(1'b0, 8'h55, 8'h2A, '{r: 8'h7F, c: 1'b0, v: 1'b0}, 1);
    idle(1);

    // Reset after four bits: no done, everything cleared, reset beats start.
    a = 8'h03; b = 8'h05;
    for (int i = 0; i < 4; i++) bitq.push_back(1'(8'h08 >> i));
    for (int i = 0; i < 4; i++) begin
      bus.start = (i == 0);
      bus.mode  = 1'b0;
      bus.in1   = a[i];
      bus.in2   = b[i];
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("midframe_busy", {31'd0, bus.busy}, 32'd1);
    #1;
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.mode  = 1'b1;
    exp_hold  = '{r: 8'h00, c: 1'b0, v: 1'b0};
    @(negedge clk);
    chk("abort_out",       {31'd0, bus.out},       32'd0);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_busy",      {31'd0, bus.busy},      32'd0);
    chk("abort_done",      {31'd0, bus.done},      32'd0);
    chk("abort_result",    {24'd0, bus.result},    32'd0);
    chk("abort_carry_out", {31'd0, bus.carry_out}, 32'd0);
    chk("abort_overflow",  {31'd0, bus.overflow},  32'd0);
    reset = 1'b1;
    // Start presented together with the first edge that has reset released.
    s_cyc = cyc;
    send_frame(1'b0, 8'h10, 8'h20, '{r: 8'h30, c: 1'b0, v: 1'b0}, 0);
    idle(2);
    chk("post_reset_latency", last_done - s_cyc, 32'd8);

    // Random frames against the word-level model.
    for (int n = 0; n < 20; n++) begin
      m = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send_frame(m, a, b, model(m, a, b), 0);
      idle($urandom_range(0, 2));
    end

    // WIDTH=1 instance: frame completes on the start edge itself.
    for (int t = 0; t < 3; t++) begin
      logic [3:0] ex;  // {result, carry_out, overflow, mode}
      case (t)
        0:       begin bus1.in1 = 1'b1; bus1.in2 = 1'b1; ex = 4'b0110; end  // 1+1
        1:       begin bus1.in1 = 1'b1; bus1.in2 = 1'b1; ex = 4'b0101; end  // 1-1
        default: begin bus1.in1 = 1'b0; bus1.in2 = 1'b1; ex = 4'b1011; end  // 0-1
      endcase
      bus1.start = 1'b1;
      bus1.mode  = ex[0];
      @(posedge clk); #1;
      bus1.start = 1'b0;
      bus1.in1   = 1'($urandom_range(0, 1));
      bus1.in2   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("w1_done",      {31'd0, bus1.done},      32'd1);
      chk("w1_result",    {31'd0, bus1.result},    {31'd0, ex[3]});
      chk("w1_carry_out", {31'd0, bus1.carry_out}, {31'd0, ex[2]});
      chk("w1_overflow",  {31'd0, bus1.overflow},  {31'd0, ex[1]});
      chk("w1_out",       {31'd0, bus1.out},       {31'd0, ex[3]});
      chk("w1_busy",      {31'd0, bus1.busy},      32'd0);
      @(negedge clk);
      chk("w1_done_pulse", {31'd0, bus1.done}, 32'd0);
      #1;
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 40 && (bitq.size() != 0 || resq.size() != 0); k++) @(posedge clk);
    @(negedge clk);
    chk("drain_bits",   bitq.size(), 32'd0);
    chk("drain_frames", resq.size(), 32'd0);
    chk("done_count",   done_cnt, frames_sent);
    chk("final_busy",   {31'd0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
